// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// It executes MULT/MULTU (and DIV/DIVU when enabled) over 32 cycles. It also
// services MFHI/MFLO/MTHI/MTLO, and it interlocks dependent HI/LO instructions
// through a combinational stall.
//
// Build option: define MULDIV_DIV_EN to include the restoring divider. When the
// macro is undefined, DIV/DIVU decode as ordinary non-HI/LO instructions and
// div_by_zero is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   ex_valid     EX instruction is valid
//   ex_flush     EX instruction is squashed this cycle (no issue)
//   ex_ALUOp     ALUOp from ID/EX, 2'b10 = R-type
//   ex_funct     funct field from ID/EX
//   ex_rs_data   forwarded Rs operand
//   ex_rt_data   forwarded Rt operand
//   stall        HI/LO instruction must wait (combinational)
//   busy         multiply/divide in progress
//   mf_result    HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi_out       HI register
//   lo_out       LO register
//   div_by_zero  one-cycle pulse when a divide by zero completes
// ----------------------------------------------------------------------------
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_flush,
   input  logic [1:0]  ex_ALUOp,
   input  logic [5:0]  ex_funct,
   input  logic [31:0] ex_rs_data,
   input  logic [31:0] ex_rt_data,
   output logic        stall,
   output logic        busy,
   output logic [31:0] mf_result,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        div_by_zero
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);
   localparam logic [1:0]       ALUOP_R   = 2'b10;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MULDIV_DIV_EN
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef MULDIV_DIV_EN
      S_DIV  = 2'd2,
`endif
      S_MUL  = 2'd1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*XLEN-1:0]     prod_q, prod_d;
   logic [XLEN-1:0]       mcand_q, mcand_d;
   logic                  negq_q, negq_d;
   logic [XLEN-1:0]       hi_q, hi_d;
   logic [XLEN-1:0]       lo_q, lo_d;
   logic                  dbz_q, dbz_d;

   // Instruction decode
   logic r_valid, op_mul, op_div, op_mfhi, op_mflo, op_mthi, op_mtlo;
   logic hilo_op, issue;

   assign r_valid = ex_valid & ~ex_flush & (ex_ALUOp == ALUOP_R);
   assign op_mul  = r_valid & ((ex_funct == F_MULT) | (ex_funct == F_MULTU));
   assign op_mfhi = r_valid & (ex_funct == F_MFHI);
   assign op_mflo = r_valid & (ex_funct == F_MFLO);
   assign op_mthi = r_valid & (ex_funct == F_MTHI);
   assign op_mtlo = r_valid & (ex_funct == F_MTLO);
`ifdef MULDIV_DIV_EN
   assign op_div  = r_valid & ((ex_funct == F_DIV) | (ex_funct == F_DIVU));
`else
   assign op_div  = 1'b0;
`endif

   assign hilo_op = op_mul | op_div | op_mfhi | op_mflo | op_mthi | op_mtlo;
   assign issue   = hilo_op & (state_q == S_IDLE);

   assign stall       = hilo_op & (state_q != S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign div_by_zero = dbz_q;
   assign mf_result   = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);

   // Operand magnitudes; funct bit 0 clear selects the signed variant
   logic            is_signed, rs_neg, rt_neg;
   logic [XLEN-1:0] rs_mag, rt_mag;

   assign is_signed = ~ex_funct[0];
   assign rs_neg    = is_signed & ex_rs_data[XLEN-1];
   assign rt_neg    = is_signed & ex_rt_data[XLEN-1];
   assign rs_mag    = rs_neg ? (~ex_rs_data + XLEN'(1)) : ex_rs_data;
   assign rt_mag    = rt_neg ? (~ex_rt_data + XLEN'(1)) : ex_rt_data;

   // Shift-add multiplier step: multiplier sits in prod low half, shifted out LSB first
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_res;

   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
   assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
   assign mul_res  = negq_q ? (~mul_next + (2*XLEN)'(1)) : mul_next;

`ifdef MULDIV_DIV_EN
   logic              negr_q, negr_d;
   logic              dz_q, dz_d;
   logic              rt_zero;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   div_qt, div_rm, div_lo, div_hi;

   assign rt_zero = (ex_rt_data == '0);

   // Restoring divider step: prod = {remainder, dividend/quotient}
   assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
   assign div_ge    = ~div_diff[XLEN+1];
   assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
   assign div_next  = {div_rem, prod_q[XLEN-2:0], div_ge};
   assign div_qt    = div_next[XLEN-1:0];
   assign div_rm    = div_next[2*XLEN-1:XLEN];

   // On divide by zero mcand holds the raw dividend, returned as HI
   assign div_lo = dz_q ? '1      : (negq_q ? (~div_qt + XLEN'(1)) : div_qt);
   assign div_hi = dz_q ? mcand_q : (negr_q ? (~div_rm + XLEN'(1)) : div_rm);
`endif

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      negq_d  = negq_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
      negr_d  = negr_q;
      dz_d    = dz_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               if (op_mul) begin
                  state_d = S_MUL;
                  cnt_d   = '0;
                  prod_d  = {{XLEN{1'b0}}, rt_mag};
                  mcand_d = rs_mag;
                  negq_d  = rs_neg ^ rt_neg;
               end
`ifdef MULDIV_DIV_EN
               else if (op_div) begin
                  state_d = S_DIV;
                  cnt_d   = '0;
                  prod_d  = {{XLEN{1'b0}}, rs_mag};
                  mcand_d = rt_zero ? ex_rs_data : rt_mag;
                  negq_d  = rs_neg ^ rt_neg;
                  negr_d  = rs_neg;
                  dz_d    = rt_zero;
               end
`endif
               else if (op_mthi) begin
                  hi_d = ex_rs_data;
               end
               else if (op_mtlo) begin
                  lo_d = ex_rs_data;
               end
            end
         end
         S_MUL: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               hi_d    = mul_res[2*XLEN-1:XLEN];
               lo_d    = mul_res[XLEN-1:0];
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
`ifdef MULDIV_DIV_EN
         S_DIV: begin
            prod_d = div_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               hi_d    = div_hi;
               lo_d    = div_lo;
               dbz_d   = dz_q;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         negq_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         negq_q  <= negq_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
         negr_q  <= negr_d;
         dz_q    <= dz_d;
`endif
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit: directed scenarios followed by a
// random instruction stream. The reference model works at the instruction
// level: HI/LO values come from plain 64-bit arithmetic, and busy time is a
// 32-cycle countdown.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [1:0] ALU_R   = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_flush;
   logic [1:0]  ex_ALUOp;
   logic [5:0]  ex_funct;
   logic [31:0] ex_rs_data, ex_rt_data;
   logic        stall, busy, div_by_zero;
   logic [31:0] mf_result, hi_out, lo_out;

   ex_muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_flush    (ex_flush),
      .ex_ALUOp    (ex_ALUOp),
      .ex_funct    (ex_funct),
      .ex_rs_data  (ex_rs_data),
      .ex_rt_data  (ex_rt_data),
      .stall       (stall),
      .busy        (busy),
      .mf_result   (mf_result),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   int          m_busy;
   bit          p_dbz, m_dbz;
   bit          last_stall;
   logic [31:0] obs_mf;
   int          dbz_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit decoded(input logic [5:0] fn);
      case (fn)
         F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU: decoded = 1'b1;
`ifdef MULDIV_DIV_EN
         F_DIV, F_DIVU: decoded = 1'b1;
`endif
         default: decoded = 1'b0;
      endcase
   endfunction

   // Instruction-level result of a mult/div
   task automatic compute(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      longint          sp;
      longint unsigned up;
      int              q, r;
      p_dbz = 1'b0;
      case (fn)
         F_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p_hi = sp[63:32];
            p_lo = sp[31:0];
         end
         F_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            p_hi = up[63:32];
            p_lo = up[31:0];
         end
         F_DIV: begin
            if (b == 32'd0) begin
               p_lo = 32'hFFFFFFFF; p_hi = a; p_dbz = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               p_lo = 32'h80000000; p_hi = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               p_lo = q; p_hi = r;
            end
         end
         default: begin
            if (b == 32'd0) begin
               p_lo = 32'hFFFFFFFF; p_hi = a; p_dbz = 1'b1;
            end else begin
               p_lo = a / b;
               p_hi = a % b;
            end
         end
      endcase
   endtask

   // One clock: drive, check combinational outputs, step edge, check registers
   task automatic cycle(input bit v, input bit f, input logic [1:0] alu, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      bit          hilo;
      logic [31:0] exp_mf;
      ex_valid = v; ex_flush = f; ex_ALUOp = alu; ex_funct = fn;
      ex_rs_data = a; ex_rt_data = b;
      @(negedge clk);
      hilo   = v && !f && (alu == ALU_R) && decoded(fn);
      exp_mf = (hilo && fn == F_MFHI) ? m_hi : ((hilo && fn == F_MFLO) ? m_lo : 32'd0);
      check("stall", stall, hilo && m_busy > 0);
      check("mf_result", mf_result, exp_mf);
      check("busy_pre", busy, m_busy > 0);
      last_stall = hilo && m_busy > 0;
      obs_mf = mf_result;
      @(posedge clk);
      #1;
      m_dbz = 1'b0;
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
         end
      end else if (hilo) begin
         case (fn)
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
               compute(fn, a, b);
               m_busy = 32;
            end
            default: ;
         endcase
      end
      check("hi_out", hi_out, m_hi);
      check("lo_out", lo_out, m_lo);
      check("busy", busy, m_busy > 0);
      check("div_by_zero", div_by_zero, m_dbz);
      if (div_by_zero) dbz_seen++;
   endtask

   // Present one valid instruction until it is accepted; report stalled cycles
   task automatic instr(input logic [1:0] alu, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, output int nstall);
      nstall = 0;
      do begin
         cycle(1'b1, 1'b0, alu, fn, a, b);
         if (last_stall) nstall++;
      end while (last_stall && nstall < 40);
      if (last_stall) check("stall_bound", 1, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 6'h00, 32'd0, 32'd0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy > 0; i++) idle(1);
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_busy = 0; m_dbz = 1'b0; p_dbz = 1'b0;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: rnd_operand = 32'd0;
         1: rnd_operand = 32'hFFFFFFFF;
         2: rnd_operand = 32'h80000000;
         3: rnd_operand = $urandom_range(0, 20);
         default: rnd_operand = $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          ns;
      logic [5:0]  ops [10];
      logic [5:0]  fn;
      logic [1:0]  alu;
      logic [31:0] a, b;
      ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_ADD, 6'h25};

      ex_valid = 1'b0; ex_flush = 1'b0; ex_ALUOp = 2'b00; ex_funct = 6'h00;
      ex_rs_data = '0; ex_rt_data = '0;
      dbz_seen = 0;
      model_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("rst_stall", stall, 0);
      check("rst_busy", busy, 0);
      check("rst_mf", mf_result, 0);
      check("rst_hi", hi_out, 0);
      check("rst_lo", lo_out, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // MTHI then an independent op then MFHI: no stalls
      instr(ALU_R, F_MTHI, 32'hA5A5A5A5, 32'd0, ns);
      check("mthi_nostall", ns, 0);
      instr(ALU_R, F_ADD, 32'd1, 32'd2, ns);
      instr(ALU_R, F_MFHI, 32'd0, 32'd0, ns);
      check("mfhi_nostall", ns, 0);
      check("mfhi_val", obs_mf, 32'hA5A5A5A5);

      // MTLO then MFLO in the next cycle
      instr(ALU_R, F_MTLO, 32'h12345678, 32'd0, ns);
      instr(ALU_R, F_MFLO, 32'd0, 32'd0, ns);
      check("mflo_after_mtlo", obs_mf, 32'h12345678);

      // Signed multiply with dependent read
      instr(ALU_R, F_MULT, 32'hFFFFFFFD, 32'd4, ns);
      check("mult_issue_nostall", ns, 0);
      instr(ALU_R, F_MFLO, 32'd0, 32'd0, ns);
      check("mult_stall_len", ns, 32);
      check("mult_mflo", obs_mf, 32'hFFFFFFF4);
      check("mult_hi", hi_out, 32'hFFFFFFFF);

      // Unsigned multiply; independent op flows while busy
      instr(ALU_R, F_MULTU, 32'hFFFFFFFF, 32'd2, ns);
      instr(ALU_R, F_ADD, 32'd3, 32'd4, ns);
      check("indep_nostall", ns, 0);
      wait_idle();
      check("multu_hi", hi_out, 32'd1);
      check("multu_lo", lo_out, 32'hFFFFFFFE);

      // Signed divide
      instr(ALU_R, F_DIV, 32'hFFFFFFF9, 32'd2, ns);
      wait_idle();
`ifdef MULDIV_DIV_EN
      check("div_lo", lo_out, 32'hFFFFFFFD);
      check("div_hi", hi_out, 32'hFFFFFFFF);
`else
      check("div_off_lo", lo_out, 32'hFFFFFFFE);
      check("div_off_hi", hi_out, 32'd1);
`endif

      // Divide by zero
      dbz_seen = 0;
      instr(ALU_R, F_DIVU, 32'd9, 32'd0, ns);
      wait_idle();
      idle(2);
`ifdef MULDIV_DIV_EN
      check("dbz_lo", lo_out, 32'hFFFFFFFF);
      check("dbz_hi", hi_out, 32'd9);
      check("dbz_pulses", dbz_seen, 1);
`else
      check("dbz_off_pulses", dbz_seen, 0);
`endif

      // Signed overflow divide
      instr(ALU_R, F_DIV, 32'h80000000, 32'hFFFFFFFF, ns);
      wait_idle();

      // Back-to-back multiplies
      instr(ALU_R, F_MULT, 32'd123, 32'hFFFFFF00, ns);
      instr(ALU_R, F_MULT, 32'd6, 32'd7, ns);
      check("b2b_stall_len", ns, 32);
      wait_idle();
      check("b2b_lo", lo_out, 32'd42);

      // Flushed issue
      cycle(1'b1, 1'b1, ALU_R, F_MULT, 32'd11, 32'd13);
      check("flush_busy", busy, 0);
      check("flush_lo", lo_out, 32'd42);

      // Random instruction stream
      for (int i = 0; i < 60; i++) begin
         fn  = ops[$urandom_range(0, 9)];
         alu = ($urandom_range(0, 9) == 0) ? 2'b00 : ALU_R;
         a   = rnd_operand();
         b   = rnd_operand();
         if ($urandom_range(0, 9) == 0)
            cycle(1'b1, 1'b1, alu, fn, a, b);
         else if ($urandom_range(0, 9) == 0)
            cycle(1'b0, 1'b0, alu, fn, a, b);
         else
            instr(alu, fn, a, b, ns);
      end
      wait_idle();

      // Reset in the middle of a multiply
      instr(ALU_R, F_MULT, 32'd5, 32'd7, ns);
      idle(9);
      ex_valid = 1'b0; ex_funct = 6'h00;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("rstmid_hi", hi_out, 0);
      check("rstmid_lo", lo_out, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_stall", stall, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(35);
      instr(ALU_R, F_MFLO, 32'd0, 32'd0, ns);
      check("rstmid_mflo", obs_mf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit with HI/LO registers, sitting in the EX stage directly downstream of the ID/EX pipeline register. It consumes the ID/EX operand, funct and ALUOp outputs, and executes MULT/MULTU/DIV/DIVU over 32 cycles. It services MFHI/MFLO/MTHI/MTLO and drives a stall interlock toward the hazard logic.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction in EX is valid (not a bubble)
- ex_flush  in  1  EX instruction is being squashed this cycle; suppresses issue
- ex_ALUOp  in  2  ALUOp from ID/EX; only 2'b10 (R-type) is decoded
- ex_funct  in  6  funct from ID/EX
- ex_rs_data  in  32  forwarded Rs operand
- ex_rt_data  in  32  forwarded Rt operand
- stall  out  1  freeze IF/ID/EX; combinational
- busy  out  1  state != IDLE
- mf_result  out  32  HI for MFHI, LO for MFLO, else 0; combinational
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- div_by_zero  out  1  one-cycle pulse on completion of a divide with rt=0

## Operation
- Decoded ops (ex_ALUOp=2'b10): 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO. All other funct values are ignored.
- hilo_op = ex_valid & ~ex_flush & decoded op.
- stall = hilo_op & (state != IDLE). Non-HI/LO instructions never stall.
- issue = hilo_op & state==IDLE. A mult/div issue latches the operand magnitudes and sign flags, clears the counter, and moves to MUL or DIV. The issuing instruction itself does not stall.
- MTHI/MTLO at issue: HI or LO <= ex_rs_data at that edge. MFHI/MFLO read the current register.
- States: IDLE -> MUL|DIV on issue. MUL/DIV run 32 iterations (counter 0..31). On iteration 31 they write HI/LO and return to IDLE.
- MUL: shift-add on unsigned magnitudes, 64-bit accumulator. For signed ops the result is negated if the signs differ. HI = product[63:32], LO = product[31:0].
- DIV: restoring, one quotient bit per cycle. LO = quotient, HI = remainder. For signed ops, quotient sign = sign(rs) ^ sign(rt) and remainder sign = sign(rs).
- Divide by zero: LO = 32'hFFFFFFFF, HI = ex_rs_data as latched. div_by_zero pulses at the completion edge.
- Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- ex_flush never aborts an operation already running.

## Timing
- Reset (rst low, asynchronous): state=IDLE, counter=0, HI=LO=0, div_by_zero=0.
  - stall, busy and mf_result read 0 immediately.
  - Reset mid-operation discards the operation with no HI/LO write.
- Issue at edge t. Iterations occupy edges t+1..t+32. HI/LO are written and state returns to IDLE at edge t+32.
- A HI/LO instruction that immediately follows the issue stalls for 32 cycles and proceeds in the cycle after edge t+32, seeing the new values.
- Independent instructions flow with zero added latency while busy.
- Back-to-back mult then mult: the second stalls 32 cycles, then issues.
- MTHI/MTLO latency is 1 edge. An MFHI in the next cycle sees the written value.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are decoded and executed as above.
- MULDIV_DIV_EN undefined:
  - The DIV state and divider datapath are compiled out.
  - DIV/DIVU are treated as undecoded: no stall, HI/LO unchanged.
  - div_by_zero is tied to 0.

## Test plan
- Reset mid-MUL:
  - Stimulus: MULT rs=5 rt=7; pull rst low at cycle 10.
  - Required: HI=LO=0, busy=0 immediately. A later MFLO returns 0.
- Signed multiply with dependent read:
  - Stimulus: MULT rs=-3 (32'hFFFFFFFD), rt=4, then immediate MFLO.
  - Required: stall high for exactly 32 cycles, then mf_result=32'hFFFFFFF4 and HI=32'hFFFFFFFF.
- Unsigned multiply:
  - Stimulus: MULTU rs=32'hFFFFFFFF, rt=2.
  - Required: HI=1, LO=32'hFFFFFFFE.
- Signed divide:
  - Stimulus: DIV rs=-7, rt=2.
  - Required: LO=-3 (32'hFFFFFFFD), HI=-1.
- Divide by zero:
  - Stimulus: DIVU rs=9, rt=0.
  - Required: LO=32'hFFFFFFFF, HI=9, div_by_zero pulses for 1 cycle.
- Move to HI, no stall:
  - Stimulus: MTHI rs=32'hA5A5A5A5, then ADD, then MFHI.
  - Required: no stall; mf_result=32'hA5A5A5A5.
- Flushed issue:
  - Stimulus: ex_flush=1 together with a MULT.
  - Required: busy stays 0, HI/LO unchanged.
